// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
// Module : ascon_pkg
// Brief  : Ascon-p state layout, rotation amounts, round constant and S-box
// Rev    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

  localparam int STATE_W   = 320;
  localparam int LANE_W    = 64;
  localparam int c_n_lanes = 5;

  // Lane k sits at state[STATE_W-1-LANE_W*k -: LANE_W], so S0 occupies the top word.
  localparam int c_lane_s0 = 0;
  localparam int c_lane_s1 = 1;
  localparam int c_lane_s2 = 2;
  localparam int c_lane_s3 = 3;
  localparam int c_lane_s4 = 4;

  localparam int c_rot_a [c_n_lanes] = '{19, 61, 1, 10, 7};
  localparam int c_rot_b [c_n_lanes] = '{28, 39, 6, 17, 41};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

  function automatic logic [7:0] rc(input logic [3:0] j);
    return {4'hF - j, j};
  endfunction

  function automatic logic [LANE_W-1:0] ror64(input logic [LANE_W-1:0] x, input int n);
    return (x >> n) | (x << (LANE_W - n));
  endfunction

  function automatic logic [LANE_W-1:0] get_lane(input logic [STATE_W-1:0] s, input int k);
    return s[STATE_W-1-LANE_W*k -: LANE_W];
  endfunction

  // Column bit 4 is the S0 bit, bit 0 the S4 bit.
  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
      5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
      5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
      5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
      5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
      5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
      5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
      5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  default: y = 5'h17;
    endcase
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round.sv
`default_nettype none
// ============================================================================
// Module : ascon_round
// Brief  : one combinational Ascon-p round; exact pass-through when disabled
// Rev    : 1.0 - initial release
// ============================================================================
module ascon_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic [7:0]         i_rc,
  input  logic               i_en,
  output logic [STATE_W-1:0] o_state
);

  logic [LANE_W-1:0] w_add [c_n_lanes];
  logic [LANE_W-1:0] w_sub [c_n_lanes];
  logic [LANE_W-1:0] w_lin [c_n_lanes];
  logic [4:0]        w_col;

  always_comb begin
    w_col = '0;
    for (int k = 0; k < c_n_lanes; k++) begin
      w_add[k] = get_lane(i_state, k);
      w_sub[k] = '0;
      w_lin[k] = '0;
    end
    w_add[c_lane_s2] = w_add[c_lane_s2] ^ {56'd0, i_rc};

    for (int b = 0; b < LANE_W; b++) begin
      w_col = sbox({w_add[c_lane_s0][b], w_add[c_lane_s1][b], w_add[c_lane_s2][b],
                    w_add[c_lane_s3][b], w_add[c_lane_s4][b]});
      w_sub[c_lane_s0][b] = w_col[4];
      w_sub[c_lane_s1][b] = w_col[3];
      w_sub[c_lane_s2][b] = w_col[2];
      w_sub[c_lane_s3][b] = w_col[1];
      w_sub[c_lane_s4][b] = w_col[0];
    end

    for (int k = 0; k < c_n_lanes; k++) begin
      w_lin[k] = w_sub[k] ^ ror64(w_sub[k], c_rot_a[k]) ^ ror64(w_sub[k], c_rot_b[k]);
    end
  end

  assign o_state = i_en ? {w_lin[c_lane_s0], w_lin[c_lane_s1], w_lin[c_lane_s2],
                           w_lin[c_lane_s3], w_lin[c_lane_s4]}
                        : i_state;

endmodule
`default_nettype wire

// File: rtl/ascon_perm_core.sv
`default_nettype none
// ============================================================================
// Module : ascon_perm_core
// Brief  : Ascon-p engine, UNROLL rounds per clock, run-time round count
// Rev    : 1.0 - initial release
// ============================================================================
module ascon_perm_core
  import ascon_pkg::*;
#(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         num_rounds,
  input  logic [STATE_W-1:0] state_in,
  output logic [STATE_W-1:0] state_out,
  output logic               busy,
  output logic               done
);

  fsm_state_e         r_fsm;
  fsm_state_e         w_fsm_nxt;
  logic [STATE_W-1:0] r_perm;
  logic [3:0]         r_rounds;
  logic [3:0]         r_ctr;
  logic               r_done;

  logic               w_load;
  logic               w_run;
  logic               w_finish;
  logic [3:0]         w_remain;
  logic               w_last;
  logic [3:0]         w_step;
  logic [3:0]         w_rounds_clamped;
  logic [STATE_W-1:0] w_chain [UNROLL+1];

  assign w_rounds_clamped = (num_rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : num_rounds;
  assign w_remain         = r_rounds - r_ctr;
  assign w_last           = (w_remain <= 4'(UNROLL));
  assign w_step           = w_last ? w_remain : 4'(UNROLL);

  assign w_chain[0] = r_perm;

  // Stage s runs round ctr+s; constants count up so the last round of any
  // operation always uses index MAX_ROUNDS-1.
  for (genvar s = 0; s < UNROLL; s++) begin : g_stage
    logic [4:0] w_pos;
    logic       w_en;
    logic [3:0] w_j;

    assign w_pos = {1'b0, r_ctr} + 5'(s);
    assign w_en  = (w_pos < {1'b0, r_rounds});
    assign w_j   = 4'(MAX_ROUNDS) - r_rounds + r_ctr + 4'(s);

    ascon_round u_round (
      .i_state (w_chain[s]),
      .i_rc    (rc(w_j)),
      .i_en    (w_en),
      .o_state (w_chain[s+1])
    );
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_load    = 1'b0;
    w_run     = 1'b0;
    w_finish  = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (start && !abort) begin
          w_load    = 1'b1;
          w_fsm_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_fsm_nxt = ST_IDLE;
        end else begin
          w_run = 1'b1;
          if (w_last) begin
            w_finish  = 1'b1;
            w_fsm_nxt = ST_IDLE;
          end
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm    <= ST_IDLE;
      r_perm   <= '0;
      r_rounds <= '0;
      r_ctr    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_done <= w_finish;
      if (w_load) begin
        r_perm   <= state_in;
        r_rounds <= w_rounds_clamped;
        r_ctr    <= '0;
      end else if (w_run) begin
        r_perm <= w_chain[UNROLL];
        r_ctr  <= r_ctr + w_step;
      end else if (abort) begin
        r_ctr <= '0;
      end
    end
  end

  assign state_out = r_perm;
  assign busy      = (r_fsm == ST_RUN);
  assign done      = r_done;

endmodule
`default_nettype wire
